sdi_key_loader: RTL and testbench

- Receiver for the LWC secret-data-input (SDI) stream.
- Parses an LDKEY instruction, then a KEY segment header, then the masked key words.
- Assembles the key shares into a register bank and presents the key to the tweak-key (TKEYX) load path with a valid/update strobe.
- Sits between the top-level sdi_* ports and the datapath key state. It replaces ad-hoc key capture in the control unit.

---
 rtl/sdi_key_loader_pkg.sv | 17 +
 rtl/sdi_key_loader.sv | 104 ++++++++++
 tb/tb_sdi_key_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdi_key_loader_pkg.sv
// Shared constants for the SDI key loader: bus width, opcodes, segment types
// and the loader FSM encoding.
package sdi_key_loader_pkg;

    localparam int SDI_BUSW = 32;

    localparam logic [3:0] OP_LDKEY = 4'h4;
    localparam logic [3:0] SEG_KEY  = 4'hC;

    typedef enum logic [1:0] {
        S_INSTR  = 2'd0,
        S_HDR    = 2'd1,
        S_DATA   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/sdi_key_loader.sv
// SDI key receiver: parses LDKEY + KEY header, assembles the masked key shares
// into a register bank and commits them to the tweak-key load path.
module sdi_key_loader
    import sdi_key_loader_pkg::*;
#(
    parameter int BUSW     = SDI_BUSW,
    parameter int SHARES   = 2,
    parameter int KEYBYTES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BUSW-1:0]             sdi_data,
    input  logic                        sdi_valid,
    output logic                        sdi_ready,
    input  logic                        key_lock,
    output logic [8*KEYBYTES*SHARES-1:0] key_data,
    output logic                        key_valid,
    output logic                        key_update,
    output logic                        key_err
);

    localparam int NW = KEYBYTES / 4;
    localparam int SW = (SHARES > 1) ? $clog2(SHARES) : 1;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;

    state_t                             state;
    logic [SW-1:0]                      share_idx;
    logic [WW-1:0]                      word_idx;
    logic [SHARES-1:0][NW-1:0][BUSW-1:0] key_words;
    logic                               accept;

    // Key word 0 sits in the top slot of each share, so the word index is reversed.
    assign key_data = key_words;
    assign accept   = sdi_valid && sdi_ready;

    always_comb begin
        sdi_ready = 1'b0;
        if (!rst) begin
            case (state)
                S_INSTR:       sdi_ready = !key_lock;
                S_HDR, S_DATA: sdi_ready = 1'b1;
                default:       sdi_ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INSTR;
            share_idx  <= '0;
            word_idx   <= '0;
            key_words  <= '0;
            key_valid  <= 1'b0;
            key_update <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            key_update <= 1'b0;
            key_err    <= 1'b0;
            case (state)
                S_INSTR: begin
                    if (accept) begin
                        if (sdi_data[31:28] == OP_LDKEY) begin
                            state     <= S_HDR;
                            key_valid <= 1'b0;
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        if (sdi_data[31:28] == SEG_KEY && sdi_data[15:0] == 16'(KEYBYTES)) begin
                            state     <= S_DATA;
                            share_idx <= '0;
                            word_idx  <= '0;
                        end else begin
                            state   <= S_INSTR;
                            key_err <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        key_words[share_idx][WW'(NW-1) - word_idx] <= sdi_data;
                        if (share_idx == SW'(SHARES-1)) begin
                            share_idx <= '0;
                            if (word_idx == WW'(NW-1)) begin
                                state      <= S_COMMIT;
                                key_valid  <= 1'b1;
                                key_update <= 1'b1;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end else begin
                            share_idx <= share_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_INSTR;
            endcase
        end
    end

endmodule

// File: tb/tb_sdi_key_loader.sv
// Directed self-checking bench for sdi_key_loader (BUSW=32, SHARES=2, KEYBYTES=16).
module tb_sdi_key_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  sdi_data;
    logic         sdi_valid;
    logic         sdi_ready;
    logic         key_lock;
    logic [255:0] key_data;
    logic         key_valid;
    logic         key_update;
    logic         key_err;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int overlap = 0;

    localparam logic [31:0]  LDKEY = 32'h4000_0000;
    localparam logic [31:0]  HDR   = 32'hC200_0010;
    localparam logic [127:0] K0    = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] K1    = 128'hA0A1A2A3B0B1B2B3C0C1C2C3D0D1D2D3;

    logic [7:0][31:0] vec_a;
    logic [7:0][31:0] vec_b;

    sdi_key_loader dut (
        .clk(clk), .rst(rst), .sdi_data(sdi_data), .sdi_valid(sdi_valid),
        .sdi_ready(sdi_ready), .key_lock(key_lock), .key_data(key_data),
        .key_valid(key_valid), .key_update(key_update), .key_err(key_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key_update) upd_cnt <= upd_cnt + 1;
        if (key_update && key_err) overlap <= overlap + 1;
    end

    // Present one word and hold it until the handshake edge; returns #1 after it.
    task automatic push(input logic [31:0] w);
        int n = 0;
        sdi_data  = w;
        sdi_valid = 1'b1;
        while (!sdi_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL push_timeout word=%h ready=%b", w, sdi_ready);
        end
        @(posedge clk); #1;
        sdi_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Sends the 8 data words in order; optional one-cycle gap after each word.
    task automatic send_data(input logic [7:0][31:0] v, input bit stall);
        for (int i = 0; i < 8; i++) begin
            push(v[i]);
            if (stall && i != 7) idle(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; key_lock = 1'b0; sdi_valid = 1'b0; sdi_data = '0;
        #1;
        checks++;
        if (sdi_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", sdi_ready); end
        @(posedge clk); #1;
        checks++;
        if (key_data !== '0 || key_valid !== 1'b0 || key_update !== 1'b0 || key_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h v=%b u=%b e=%b exp all 0", key_data, key_valid, key_update, key_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sdi_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", sdi_ready); end
    endtask

    task automatic test_nominal;
        int u0;
        u0 = upd_cnt;
        push(LDKEY);
        push(HDR);
        send_data(vec_a, 1'b0);
        checks++;
        if (key_update !== 1'b1 || key_valid !== 1'b1 || sdi_ready !== 1'b0) begin
            errors++;
            $display("FAIL nominal_commit got u=%b v=%b r=%b exp u=1 v=1 r=0", key_update, key_valid, sdi_ready);
        end
        checks++;
        if (key_data !== {128'h0, K0}) begin
            errors++; $display("FAIL nominal_key got=%h exp=%h", key_data, {128'h0, K0});
        end
        idle(1);
        checks++;
        if (key_update !== 1'b0 || sdi_ready !== 1'b1 || upd_cnt != u0 + 1) begin
            errors++;
            $display("FAIL nominal_after got u=%b r=%b pulses=%0d exp u=0 r=1 pulses=1", key_update, sdi_ready, upd_cnt - u0);
        end
    endtask

    task automatic test_stalled;
        int u0;
        u0 = upd_cnt;
        push(LDKEY);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_clear got=%b exp=0", key_valid); end
        idle(1);
        push(HDR);
        idle(1);
        for (int i = 0; i < 7; i++) begin
            push(vec_a[i]);
            idle(1);
        end
        checks++;
        if (upd_cnt != u0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL stall_early_commit got pulses=%0d v=%b exp pulses=0 v=0", upd_cnt - u0, key_valid);
        end
        push(vec_a[7]);
        checks++;
        if (key_update !== 1'b1 || key_data !== {128'h0, K0}) begin
            errors++; $display("FAIL stall_commit got u=%b data=%h exp u=1 data=%h", key_update, key_data, {128'h0, K0});
        end
        idle(2);
        checks++;
        if (upd_cnt != u0 + 1) begin errors++; $display("FAIL stall_pulses got=%0d exp=1", upd_cnt - u0); end
    endtask

    task automatic test_bad_opcode;
        push(32'h7000_0000);
        checks++;
        if (key_err !== 1'b1 || key_valid !== 1'b1 || sdi_ready !== 1'b1) begin
            errors++; $display("FAIL badop got e=%b v=%b r=%b exp e=1 v=1 r=1", key_err, key_valid, sdi_ready);
        end
        idle(1);
        checks++;
        if (key_err !== 1'b0) begin errors++; $display("FAIL badop_pulse got=%b exp=0", key_err); end
        test_nominal();
    endtask

    task automatic test_bad_header;
        push(LDKEY);
        push(32'hC200_0020);
        checks++;
        if (key_err !== 1'b1 || key_valid !== 1'b0 || sdi_ready !== 1'b1) begin
            errors++; $display("FAIL badhdr got e=%b v=%b r=%b exp e=1 v=0 r=1", key_err, key_valid, sdi_ready);
        end
        // next word must be parsed as an instruction, so a full load follows directly
        test_nominal();
    endtask

    task automatic test_key_lock;
        key_lock  = 1'b1;
        sdi_data  = LDKEY;
        sdi_valid = 1'b1;
        idle(3);
        checks++;
        if (sdi_ready !== 1'b0 || key_valid !== 1'b1) begin
            errors++; $display("FAIL lock_hold got r=%b v=%b exp r=0 v=1", sdi_ready, key_valid);
        end
        key_lock = 1'b0;
        #1;
        checks++;
        if (sdi_ready !== 1'b1) begin errors++; $display("FAIL lock_release got r=%b exp=1", sdi_ready); end
        push(LDKEY);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL lock_accept got v=%b exp=0", key_valid); end
        // lock raised mid-load must not stall the stream
        key_lock = 1'b1;
        push(HDR);
        send_data(vec_b, 1'b0);
        checks++;
        if (key_update !== 1'b1 || key_data !== {K1, K0}) begin
            errors++; $display("FAIL lock_midload got u=%b data=%h exp u=1 data=%h", key_update, key_data, {K1, K0});
        end
        idle(1);
        checks++;
        if (sdi_ready !== 1'b0) begin errors++; $display("FAIL lock_instr_ready got=%b exp=0", sdi_ready); end
        key_lock = 1'b0;
    endtask

    task automatic test_reset_midload;
        push(LDKEY);
        push(HDR);
        for (int i = 0; i < 4; i++) push(vec_b[i]);
        rst = 1'b1;
        #1;
        checks++;
        if (sdi_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", sdi_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (key_data !== '0 || key_valid !== 1'b0 || sdi_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_state got data=%h v=%b r=%b exp 0/0/1", key_data, key_valid, sdi_ready);
        end
        push(LDKEY);
        push(HDR);
        send_data(vec_b, 1'b0);
        checks++;
        if (key_update !== 1'b1 || key_valid !== 1'b1 || key_data !== {K1, K0}) begin
            errors++; $display("FAIL midrst_reload got u=%b v=%b data=%h exp u=1 v=1 data=%h", key_update, key_valid, key_data, {K1, K0});
        end
        idle(2);
    endtask

    initial begin
        vec_a[0] = 32'h00010203; vec_a[1] = 32'h0; vec_a[2] = 32'h04050607; vec_a[3] = 32'h0;
        vec_a[4] = 32'h08090A0B; vec_a[5] = 32'h0; vec_a[6] = 32'h0C0D0E0F; vec_a[7] = 32'h0;
        vec_b[0] = 32'h00010203; vec_b[1] = 32'hA0A1A2A3; vec_b[2] = 32'h04050607; vec_b[3] = 32'hB0B1B2B3;
        vec_b[4] = 32'h08090A0B; vec_b[5] = 32'hC0C1C2C3; vec_b[6] = 32'h0C0D0E0F; vec_b[7] = 32'hD0D1D2D3;

        test_reset();
        test_nominal();
        test_stalled();
        test_bad_opcode();
        test_bad_header();
        test_key_lock();
        test_reset_midload();

        checks++;
        if (overlap != 0) begin errors++; $display("FAIL err_update_overlap got=%0d exp=0", overlap); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
